// File: rtl/mult_div_unit.sv
// E-stage multiply/divide unit owning the HI/LO registers, with a countdown modelling latency.
// Optional MADD/MADDU/MSUB/MSUBU accumulate ops are enabled by defining MDU_MADD_EN.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        rd_sel,
    output logic        busy,
    output logic [31:0] rd_data
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [63:0] pend_q, pend_d;
    logic        pend_wr_q, pend_wr_d;

    logic        is_mul, is_div, is_mac, launch, div_zero, div_ovf;
    logic signed [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] divisor;
    logic signed [31:0] a_s, d_s, q_s, r_s;
    logic [31:0] q_u, r_u;
    logic [63:0] result;

    assign busy    = (state_q == RUN);
    assign rd_data = rd_sel ? hi_q : lo_q;

    // Datapath: all candidate results are computed from the current operands every cycle.
    always_comb begin
        prod_s   = $signed(A) * $signed(B);
        prod_u   = {32'd0, A} * {32'd0, B};
        div_zero = (B == 32'd0);
        div_ovf  = (A == 32'h8000_0000) && (B == 32'hFFFF_FFFF);
        divisor  = div_zero ? 32'd1 : B;
        a_s      = $signed(A);
        d_s      = $signed(divisor);
        q_s      = div_ovf ? 32'sh8000_0000 : (a_s / d_s);
        r_s      = div_ovf ? 32'sd0 : (a_s % d_s);
        q_u      = A / divisor;
        r_u      = A % divisor;
        result   = 64'd0;
        case (mdu_op)
            OP_MULT:  result = $unsigned(prod_s);
            OP_MULTU: result = prod_u;
            OP_DIV:   result = {$unsigned(r_s), $unsigned(q_s)};
            OP_DIVU:  result = {r_u, q_u};
`ifdef MDU_MADD_EN
            OP_MADD:  result = {hi_q, lo_q} + $unsigned(prod_s);
            OP_MADDU: result = {hi_q, lo_q} + prod_u;
            OP_MSUB:  result = {hi_q, lo_q} - $unsigned(prod_s);
            OP_MSUBU: result = {hi_q, lo_q} - prod_u;
`endif
            default:  result = 64'd0;
        endcase
    end

    always_comb begin
        is_mul = (mdu_op == OP_MULT) || (mdu_op == OP_MULTU);
        is_div = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);
`ifdef MDU_MADD_EN
        is_mac = (mdu_op >= OP_MADD) && (mdu_op <= OP_MSUBU);
`else
        is_mac = 1'b0;
`endif
        launch = start && (state_q == IDLE) && (is_mul || is_div || is_mac);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_d    = pend_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d   = RUN;
                    cnt_d     = is_div ? 5'(DIV_CYCLES) : 5'(MULT_CYCLES);
                    pend_d    = result;
                    // A zero divisor still occupies the unit but leaves HI/LO untouched.
                    pend_wr_d = !(is_div && div_zero);
                end else if (mdu_op == OP_MTHI) begin
                    hi_d = A;
                end else if (mdu_op == OP_MTLO) begin
                    lo_d = A;
                end
            end
            RUN: begin
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_q[63:32];
                        lo_d = pend_q[31:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_q    <= 64'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_q    <= pend_d;
            pend_wr_q <= pend_wr_d;
        end
    end

endmodule
